// File: rtl/xy_input_port_pkg.sv
// Shared constants for the mesh input port: output-port encoding and the
// location of the destination coordinate fields inside a flit.
package xy_input_port_pkg;

   localparam int PORT_SEL_W = 3;
   localparam int PORT_N     = 5;

   // Encoding matches the crossbar select lines.
   typedef enum logic [PORT_SEL_W-1:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      EAST  = 3'd2,
      SOUTH = 3'd3,
      WEST  = 3'd4
   } port_e;

   localparam int DST_X_LSB = 0;
   localparam int DST_X_W   = 2;
   localparam int DST_Y_LSB = DST_X_LSB + DST_X_W;
   localparam int DST_Y_W   = 2;

endpackage

// File: rtl/xy_input_port_if.sv
// Link-side and switch-side signals of one router input port; the port is
// the slave, the upstream router / switch allocator side is the master.
interface xy_input_port_if
   import xy_input_port_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_W      = 3
);
   logic [DATA_WIDTH-1:0] data_i;
   logic                  vld_i;
   logic                  rdy_o;
   logic                  grant_i;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  vld_o;
   logic [PORT_SEL_W-1:0] route_o;
   logic [CNT_W-1:0]      count_o;

   modport slave (
      input  data_i, vld_i, grant_i,
      output rdy_o, data_o, vld_o, route_o, count_o
   );

   modport master (
      output data_i, vld_i, grant_i,
      input  rdy_o, data_o, vld_o, route_o, count_o
   );
endinterface

// File: rtl/xy_input_port_sync_fifo.sv
// Small first-word-fall-through FIFO: head is read straight out of storage,
// flags and occupancy derive from a count that clears asynchronously.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   localparam int PTR_W     = $clog2(DEPTH),
   localparam int CNT_W     = PTR_W + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_req_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  pop_req_i,
   output logic                  rdy_o,
   output logic                  vld_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic [CNT_W-1:0]      count_o
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  push, pop;

   assign rdy_o = (count_q != CNT_W'(DEPTH));
   assign vld_o = (count_q != '0);
   assign push  = push_req_i & rdy_o;
   assign pop   = pop_req_i & vld_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = vld_o ? mem_q[rd_ptr_q] : '0;
   assign count_o   = count_q;
endmodule

// File: rtl/xy_input_port.sv
// Router input port: buffers incoming single-flit packets and requests the
// XY dimension-ordered output port for the head flit.
module xy_input_port
   import xy_input_port_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int X_W        = DST_X_W,
   parameter int Y_W        = DST_Y_W,
   parameter int ROUTER_X   = 1,
   parameter int ROUTER_Y   = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   xy_input_port_if.slave port_if
);
   localparam logic [X_W-1:0] RX = X_W'(ROUTER_X);
   localparam logic [Y_W-1:0] RY = Y_W'(ROUTER_Y);

   logic [DATA_WIDTH-1:0] head;
   logic                  head_vld;
   logic [X_W-1:0]        dst_x;
   logic [Y_W-1:0]        dst_y;
   port_e                 route;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_req_i (port_if.vld_i),
      .wr_data_i  (port_if.data_i),
      .pop_req_i  (port_if.grant_i),
      .rdy_o      (port_if.rdy_o),
      .vld_o      (head_vld),
      .rd_data_o  (head),
      .count_o    (port_if.count_o)
   );

   assign dst_x = head[X_W-1:0];
   assign dst_y = head[X_W+Y_W-1:X_W];

   // X is resolved fully before Y; comparisons are unsigned.
   always_comb begin
      route = LOCAL;
      if (head_vld) begin
         if (dst_x > RX)      route = EAST;
         else if (dst_x < RX) route = WEST;
         else if (dst_y > RY) route = NORTH;
         else if (dst_y < RY) route = SOUTH;
         else                 route = LOCAL;
      end
   end

   assign port_if.data_o  = head;
   assign port_if.vld_o   = head_vld;
   assign port_if.route_o = route;
endmodule

// File: tb/tb_xy_input_port.sv
// Bench for xy_input_port at router (1,1), depth 4: table-driven pushes plus
// a scoreboard of expected head flits checked on every granted pop.
module tb_xy_input_port;
   logic clk;
   logic rst;

   xy_input_port_if #(.DATA_WIDTH(8), .CNT_W(3)) dut_if ();

   xy_input_port #(
      .DATA_WIDTH (8),
      .X_W        (2),
      .Y_W        (2),
      .ROUTER_X   (1),
      .ROUTER_Y   (1),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .port_if (dut_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] route;
   } sb_t;

   typedef struct {
      logic [7:0] data;
      logic [2:0] route;
   } vec_t;

   sb_t sb_q[$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  exp_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // XY routing reference for router (1,1): X first, then Y (north = +Y).
   function automatic logic [2:0] ref_route(input logic [7:0] f);
      int x = int'(f[1:0]);
      int y = int'(f[3:2]);
      if (x > 1) return 3'd2;
      if (x < 1) return 3'd4;
      if (y > 1) return 3'd1;
      if (y < 1) return 3'd3;
      return 3'd0;
   endfunction

   // One clock: drive inputs, account for push/pop, then check occupancy.
   task automatic cycle(input logic v, input logic [7:0] d, input logic g, input logic [2:0] r);
      sb_t e;
      dut_if.vld_i   = v;
      dut_if.data_i  = d;
      dut_if.grant_i = g;
      if (v && dut_if.rdy_o) begin
         sb_q.push_back({d, r});
         exp_count++;
         $display("push data=%02h route=%0d", d, r);
      end
      if (g && dut_if.vld_o) begin
         if (sb_q.size() == 0) begin
            chk("pop_unexpected", 32'(dut_if.vld_o), 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("pop_data", 32'(dut_if.data_o), 32'(e.data));
            chk("pop_route", 32'(dut_if.route_o), 32'(e.route));
            $display("pop  data=%02h route=%0d", dut_if.data_o, dut_if.route_o);
         end
         exp_count--;
      end
      @(posedge clk);
      #1;
      chk("count", 32'(dut_if.count_o), 32'(exp_count));
      chk("vld_flag", 32'(dut_if.vld_o), 32'(exp_count != 0));
      chk("rdy_flag", 32'(dut_if.rdy_o), 32'(exp_count != 4));
   endtask

   vec_t vec [4];
   logic [7:0] f;

   initial begin
      vec[0] = '{8'h05, 3'd0};
      vec[1] = '{8'h09, 3'd1};
      vec[2] = '{8'h00, 3'd4};
      vec[3] = '{8'h01, 3'd3};

      rst = 1'b1;
      dut_if.vld_i   = 1'b0;
      dut_if.data_i  = 8'h00;
      dut_if.grant_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_vld", 32'(dut_if.vld_o), 32'd0);
      chk("reset_rdy", 32'(dut_if.rdy_o), 32'd1);
      chk("reset_count", 32'(dut_if.count_o), 32'd0);
      chk("reset_route", 32'(dut_if.route_o), 32'd0);
      chk("reset_data", 32'(dut_if.data_o), 32'd0);

      // Grant while empty must be ignored.
      cycle(1'b0, 8'h00, 1'b1, 3'd0);

      // Single flit east-bound, then granted away.
      cycle(1'b1, 8'h03, 1'b0, 3'd2);
      chk("single_vld", 32'(dut_if.vld_o), 32'd1);
      chk("single_data", 32'(dut_if.data_o), 32'h03);
      chk("single_route", 32'(dut_if.route_o), 32'd2);
      cycle(1'b0, 8'h00, 1'b1, 3'd0);
      chk("single_empty_route", 32'(dut_if.route_o), 32'd0);

      // Fill from the table.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, vec[i].data, 1'b0, vec[i].route);
         chk("fill_head", 32'(dut_if.data_o), 32'(vec[0].data));
      end
      chk("full_rdy", 32'(dut_if.rdy_o), 32'd0);
      cycle(1'b1, 8'h07, 1'b0, ref_route(8'h07));
      chk("full_reject_count", 32'(dut_if.count_o), 32'd4);

      // Full with push and grant together: only the pop happens.
      cycle(1'b1, 8'h07, 1'b1, ref_route(8'h07));
      chk("full_grant_count", 32'(dut_if.count_o), 32'd3);
      cycle(1'b1, 8'h07, 1'b0, ref_route(8'h07));
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 3'd0);

      // Streaming: one flit in and one out every cycle, pointers wrap 5x.
      for (int k = 0; k < 20; k++) begin
         f = 8'($urandom_range(0, 255));
         cycle(1'b1, f, 1'b1, ref_route(f));
         chk("stream_count", 32'(dut_if.count_o), 32'd1);
         chk("stream_head", 32'(dut_if.data_o), 32'(f));
      end
      cycle(1'b0, 8'h00, 1'b1, 3'd0);

      // Asynchronous reset with three flits buffered.
      for (int i = 0; i < 3; i++) cycle(1'b1, vec[i].data, 1'b0, vec[i].route);
      chk("pre_reset_count", 32'(dut_if.count_o), 32'd3);
      dut_if.vld_i = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_vld", 32'(dut_if.vld_o), 32'd0);
      chk("async_rst_count", 32'(dut_if.count_o), 32'd0);
      chk("async_rst_rdy", 32'(dut_if.rdy_o), 32'd1);
      chk("async_rst_route", 32'(dut_if.route_o), 32'd0);
      sb_q.delete();
      exp_count = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle(1'b1, 8'h0C, 1'b0, 3'd4);
      cycle(1'b0, 8'h00, 1'b1, 3'd0);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
